// File: rtl/not_gate_arbiter.sv
// not_gate_arbiter: round-robin shared WIDTH-bit inverter for 4 requesters; define NOT_ARB_TIMEOUT_EN for a DONE timeout with sticky err
module not_gate_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] A,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   Y,
  output logic               valid,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  state_t     state;
  logic [1:0] last, win, pick;
  logic       tmo;
  always_comb begin
    pick = last;
    for (int i = 4; i >= 1; i--)
      if (req[last + 2'(i)]) pick = last + 2'(i);
  end
`ifdef NOT_ARB_TIMEOUT_EN
  logic [3:0] cnt;
  assign tmo = cnt == 4'd14;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == DONE ? cnt + 4'd1 : 4'd0;
      if (state == DONE && req[win] && tmo) err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      valid <= 1'b0;
      Y     <= '0;
      last  <= 2'd3;
      win   <= 2'd0;
    end else case (state)
      IDLE: if (|req) begin
        win   <= pick;
        gnt   <= 4'b0001 << pick;
        state <= GRANT;
      end
      GRANT: begin
        Y     <= ~A[win*WIDTH +: WIDTH];
        valid <= 1'b1;
        state <= DONE;
      end
      default: if (!req[win] || tmo) begin
        gnt   <= '0;
        valid <= 1'b0;
        last  <= win;
        state <= IDLE;
      end
    endcase
endmodule

// File: tb/tb_not_gate_arbiter.sv
// tb_not_gate_arbiter: directed and randomized checks of not_gate_arbiter against a transaction-level model
module tb_not_gate_arbiter;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [4*W-1:0] A = '0;
  logic [3:0] gnt;
  logic [W-1:0] Y;
  logic valid, err;
  int compared = 0, mismatched = 0;
  int owner = -1, age = 0, last = 3;
  logic [W-1:0] my = '0;
  bit merr = 1'b0;
  logic [3:0] seen = '0;
`ifdef NOT_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  always #5 clk = ~clk;
  not_gate_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .req(req), .A(A),
                                     .gnt(gnt), .Y(Y), .valid(valid), .err(err));
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      owner = -1; age = 0; last = 3; my = '0; merr = 1'b0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++)
        if (owner < 0 && req[(last + k) % 4]) owner = (last + k) % 4;
      age = 0;
    end else if (age == 0) begin
      my = ~A[owner*W +: W];
      age = 1;
    end else if (!req[owner] || (TMO && age == 15)) begin
      if (req[owner]) merr = 1'b1;
      last = owner;
      owner = -1;
    end else age++;
  end
  always @(posedge clk) begin
    #1;
    check("model_gnt", gnt, owner < 0 ? 0 : (1 << owner));
    check("model_valid", valid, owner >= 0 && age >= 1);
    check("model_y", Y, my);
    check("model_err", err, merr);
  end
  task automatic serve(int i, logic [7:0] a, bit reraise);
    check("rr_gnt", gnt, 4'b0001 << i);
    @(negedge clk);
    check("rr_valid", valid, 1);
    check("rr_y", Y, 8'(~a));
    req[i] = 1'b0;
    @(negedge clk);
    check("rr_release_gnt", gnt, 0);
    check("rr_release_valid", valid, 0);
    if (reraise) req[i] = 1'b1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_gnt", gnt, 0);
    check("reset_valid", valid, 0);
    check("reset_y", Y, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1; req = 4'b0001; A[7:0] = 8'hA5;
    @(negedge clk);
    check("single_gnt", gnt, 4'b0001);
    check("single_valid_early", valid, 0);
    @(negedge clk);
    check("single_valid", valid, 1);
    check("single_y", Y, 8'h5A);
    req = '0;
    @(negedge clk);
    check("single_release_gnt", gnt, 0);
    check("single_release_valid", valid, 0);
    check("single_y_retained", Y, 8'h5A);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1111; A = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    serve(0, 8'h11, 1); @(negedge clk);
    serve(1, 8'h22, 1); @(negedge clk);
    serve(2, 8'h33, 1); @(negedge clk);
    serve(3, 8'h44, 1); @(negedge clk);
    serve(0, 8'h11, 0);
    req = '0;
    @(negedge clk);
    check("idle_gnt", gnt, 0);
    req = 4'b0100; A[23:16] = 8'h3C;
    @(negedge clk);
    serve(2, 8'h3C, 0);
    req = 4'b1001; A[31:24] = 8'h81; A[7:0] = 8'h7E;
    @(negedge clk);
    serve(3, 8'h81, 0);
    @(negedge clk);
    serve(0, 8'h7E, 0);
    req = 4'b0010; A[15:8] = 8'h0F;
    @(negedge clk);
    check("stab_gnt", gnt, 4'b0010);
    @(negedge clk);
    check("stab_y", Y, 8'hF0);
    A[15:8] = 8'hFF; req[2] = 1'b1; A[23:16] = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("stab_hold_y", Y, 8'hF0);
      check("stab_hold_gnt", gnt, 4'b0010);
    end
    req[1] = 1'b0;
    @(negedge clk);
    check("stab_release", gnt, 0);
    @(negedge clk);
    check("stab_next_gnt", gnt, 4'b0100);
    @(negedge clk);
    check("rst_pre_valid", valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_y", Y, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_gnt", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    check("drop_in_grant_valid", valid, 1);
    check("drop_in_grant_y", Y, 8'hAA);
    @(negedge clk);
    check("drop_in_grant_release", gnt, 0);
    req = 4'b0001; A[7:0] = 8'h00;
    @(negedge clk);
    check("tmo_gnt", gnt, 4'b0001);
    repeat (15) @(negedge clk);
    check("tmo_hold_valid", valid, 1);
    check("tmo_hold_err", err, 0);
    @(negedge clk);
`ifdef NOT_ARB_TIMEOUT_EN
    check("tmo_forced_gnt", gnt, 0);
    check("tmo_forced_valid", valid, 0);
    check("tmo_err", err, 1);
`else
    check("notmo_gnt", gnt, 4'b0001);
    check("notmo_err", err, 0);
`endif
    req = '0;
    repeat (3) @(negedge clk);
    check("tmo_after_gnt", gnt, 0);
    check("tmo_err_sticky", err, TMO);
    repeat (3000) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        seen = '0;
      end
      for (int i = 0; i < 4; i++) begin
        if (owner == i && age >= 1) seen[i] = 1'b1;
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            A[i*W +: W] = 8'($urandom);
            req[i] = 1'b1;
            seen[i] = 1'b0;
          end
        end else if (seen[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b0;
          seen[i] = 1'b0;
        end else if (owner == i && age >= 1 && $urandom_range(3) == 0)
          A[i*W +: W] = 8'($urandom);
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
